// File: rtl/program_sequencer.sv
// Program sequencer: stores a nibble program and replays it to a downstream stack CPU,
// holding each opcode/operand on cpu_inbits for the number of cycles the CPU needs.
module program_sequencer #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [3:0] load_nibble,
    output logic       load_ready,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] cpu_inbits,
    output logic       cpu_rst,
    output logic       running,
    output logic       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        RESET_CPU,
        FETCH,
        EXEC,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [CW-1:0] pc, pc_n, pc_p1;
    logic [1:0]    exec_cnt, exec_n;
    logic [3:0]    inbits_n;
    logic [3:0]    op;
    logic [3:0]    operand;
    logic          wr_en;
    logic [3:0]    mem [DEPTH];

    function automatic logic has_operand(input logic [3:0] o);
        return o inside {4'h1, 4'h6, 4'h7, 4'h8};
    endfunction

    // EXEC cycles beyond the first one for a given opcode.
    function automatic logic [1:0] exec_extra(input logic [3:0] o);
        case (o)
            4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: return 2'd1;
            4'h9, 4'hA:                         return 2'd2;
            default:                            return 2'd0;
        endcase
    endfunction

    assign pc_p1   = pc + CW'(1);
    assign op      = mem[pc[AW-1:0]];
    assign operand = (pc_p1 < count) ? mem[pc_p1[AW-1:0]] : 4'h0;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_n  = state;
        count_n  = count;
        pc_n     = pc;
        exec_n   = exec_cnt;
        inbits_n = 4'h0;
        wr_en    = 1'b0;

        if (stop && state != IDLE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        count_n = '0;
                    end else if (load_valid && load_ready) begin
                        wr_en   = 1'b1;
                        count_n = count + CW'(1);
                    end
                    // A nibble accepted alongside start is still stored and becomes part of the run.
                    if (start && !stop && !clear && count != '0) begin
                        state_n = RESET_CPU;
                        pc_n    = '0;
                    end
                end
                RESET_CPU: begin
                    state_n  = FETCH;
                    inbits_n = op;
                end
                FETCH: begin
                    if (op == 4'hF) begin
                        state_n = DONE;
                    end else begin
                        state_n = EXEC;
                        exec_n  = exec_extra(op);
                        if (has_operand(op)) begin
                            inbits_n = operand;
                            pc_n     = pc + CW'(2);
                        end else begin
                            pc_n     = pc_p1;
                        end
                    end
                end
                EXEC: begin
                    if (exec_cnt != 2'd0) begin
                        exec_n   = exec_cnt - 2'd1;
                        inbits_n = cpu_inbits;
                    end else if (pc >= count) begin
                        state_n = DONE;
                    end else begin
                        state_n  = FETCH;
                        inbits_n = op;
                    end
                end
                DONE: begin
                    if (clear) begin
                        count_n = '0;
                        state_n = IDLE;
                    end else if (start && count != '0) begin
                        state_n = RESET_CPU;
                        pc_n    = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (rst) begin
            wr_en = 1'b0;
        end
    end

    // NOTE: the program memory has no reset; its contents are meaningless until count covers them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= load_nibble;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            pc         <= '0;
            exec_cnt   <= 2'd0;
            cpu_inbits <= 4'h0;
            cpu_rst    <= 1'b1;
            load_ready <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            pc         <= pc_n;
            exec_cnt   <= exec_n;
            cpu_inbits <= inbits_n;
            cpu_rst    <= (state_n == RESET_CPU);
            load_ready <= (state_n == IDLE) && (count_n < CW'(DEPTH));
            running    <= (state_n == RESET_CPU) || (state_n == FETCH) || (state_n == EXEC);
            done       <= (state_n == DONE);
        end
    end

endmodule
